// File: rtl/s_add_pkg.sv
// s_add_pkg: shared constants and helpers for the small-offset adder family.
//   S_ADD_BW    : offset width (fixed at 5)
//   S_ADD_P_DEF : default operand/result width
//   S_ADD_MAXW  : widest operand zext_b can serve
//   zext_b()    : zero-extends a 5-bit offset to S_ADD_MAXW bits. Callers
//                 size-cast the result to their own operand width.
package s_add_pkg;

  localparam int S_ADD_BW    = 5;
  localparam int S_ADD_P_DEF = 8;
  localparam int S_ADD_MAXW  = 64;

  function automatic logic [S_ADD_MAXW-1:0] zext_b(input logic [S_ADD_BW-1:0] b);
    return {{(S_ADD_MAXW-S_ADD_BW){1'b0}}, b};
  endfunction

endpackage

// File: rtl/s_add_core.sv
// s_add_core: purely combinational P-bit + 5-bit unsigned adder.
// It is kept separate from the register stage so a carry-lookahead
// variant can be dropped in without touching the top level.
//   a   in  [P-1:0]   operand
//   b   in  [BW-1:0]  offset, zero-extended to P bits
//   sum out [P-1:0]   low P bits of a + b
//   co  out           carry out of bit P-1
module s_add_core
  import s_add_pkg::*;
#(
  parameter int P  = S_ADD_P_DEF,
  parameter int BW = S_ADD_BW
) (
  input  logic [P-1:0]  a,
  input  logic [BW-1:0] b,
  output logic [P-1:0]  sum,
  output logic          co
);

  logic [P-1:0] bext;
  logic [P:0]   s;

  assign bext = P'(zext_b(b));
  assign s    = {1'b0, a} + {1'b0, bext};
  assign sum  = s[P-1:0];
  assign co   = s[P];

endmodule

// File: rtl/s_add.sv
// s_add: registered small-offset adder, Y = A + zext(B), latency 1.
// Optional build macro S_ADD_SATURATE_EN: on carry-out, Y clamps to all
// ones instead of wrapping; co still reports 1 so the clamp is visible.
//   clk   in             rising-edge clock
//   rst   in             async active-high reset (clears Y, co, valid)
//   en    in             load enable
//   A     in  [P-1:0]    unsigned operand
//   B     in  [BW-1:0]   unsigned offset
//   Y     out [P-1:0]    registered sum
//   co    out            registered carry-out
//   valid out            one-cycle pulse per enabled load
module s_add
  import s_add_pkg::*;
#(
  parameter int P  = S_ADD_P_DEF,
  parameter int BW = S_ADD_BW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic [P-1:0]  A,
  input  logic [BW-1:0] B,
  output logic [P-1:0]  Y,
  output logic          co,
  output logic          valid
);

  // Elaboration-time guard on the parameter space.
  if (BW != S_ADD_BW || P < S_ADD_BW || P > S_ADD_MAXW) begin : g_bad_param
    $error("s_add: illegal parameters P=%0d BW=%0d", P, BW);
  end

  logic [P-1:0] sum;
  logic         c;
  logic [P-1:0] y_nxt;

  s_add_core #(.P(P), .BW(BW)) u_core (
    .a   (A),
    .b   (B),
    .sum (sum),
    .co  (c)
  );

`ifdef S_ADD_SATURATE_EN
  assign y_nxt = c ? '1 : sum;
`else
  assign y_nxt = sum;
`endif

  // A/B are only captured under en, so X on them while idle never reaches Y.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      Y     <= '0;
      co    <= 1'b0;
      valid <= 1'b0;
    end else begin
      valid <= en;
      if (en) begin
        Y  <= y_nxt;
        co <= c;
      end
    end
  end

endmodule

// File: tb/tb_s_add.sv
// tb_s_add: scoreboard bench for s_add at P=8 and P=16.
module tb_s_add;

  logic        clk = 1'b0;
  logic        rst;
  logic        en8, en16;
  logic [7:0]  a8;
  logic [4:0]  b8, b16;
  logic [15:0] a16;
  logic [7:0]  y8;
  logic [15:0] y16;
  logic        co8, co16, v8, v16;

  int tests = 0;
  int fails = 0;

  logic [8:0]  q8[$];
  logic [16:0] q16[$];
  logic [8:0]  last8;
  logic [16:0] last16;

  always #5 clk = ~clk;

  s_add #(.P(8)) dut8 (
    .clk(clk), .rst(rst), .en(en8), .A(a8), .B(b8), .Y(y8), .co(co8), .valid(v8)
  );

  s_add #(.P(16)) dut16 (
    .clk(clk), .rst(rst), .en(en16), .A(a16), .B(b16), .Y(y16), .co(co16), .valid(v16)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model, {co, y}.
  function automatic logic [8:0] mdl8(input logic [7:0] a, input logic [4:0] b);
    logic [8:0] s;
    s = {1'b0, a} + {4'b0, b};
`ifdef S_ADD_SATURATE_EN
    if (s[8]) s = 9'h1FF;
`endif
    return s;
  endfunction

  function automatic logic [16:0] mdl16(input logic [15:0] a, input logic [4:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {12'b0, b};
`ifdef S_ADD_SATURATE_EN
    if (s[16]) s = 17'h1FFFF;
`endif
    return s;
  endfunction

  // Drive one P=8 cycle; push expectation on load, check 1ns after the edge.
  task automatic cyc8(input logic e, input logic [7:0] a, input logic [4:0] b);
    logic [8:0] x;
    en8 = e; a8 = a; b8 = b;
    if (e) q8.push_back(mdl8(a, b));
    @(posedge clk); #1;
    chk("valid8", {31'b0, v8}, {31'b0, e});
    if (v8) begin
      if (q8.size() == 0) chk("q8_empty", 32'd1, 32'd0);
      else begin
        x = q8.pop_front();
        last8 = x;
        chk("y8", {24'b0, y8}, {24'b0, x[7:0]});
        chk("co8", {31'b0, co8}, {31'b0, x[8]});
      end
    end else begin
      chk("hold_y8", {24'b0, y8}, {24'b0, last8[7:0]});
      chk("hold_co8", {31'b0, co8}, {31'b0, last8[8]});
    end
  endtask

  task automatic cyc16(input logic e, input logic [15:0] a, input logic [4:0] b);
    logic [16:0] x;
    en16 = e; a16 = a; b16 = b;
    if (e) q16.push_back(mdl16(a, b));
    @(posedge clk); #1;
    chk("valid16", {31'b0, v16}, {31'b0, e});
    if (v16) begin
      if (q16.size() == 0) chk("q16_empty", 32'd1, 32'd0);
      else begin
        x = q16.pop_front();
        last16 = x;
        chk("y16", {16'b0, y16}, {16'b0, x[15:0]});
        chk("co16", {31'b0, co16}, {31'b0, x[16]});
      end
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_y8"},  {24'b0, y8}, 32'd0);
    chk({tag, "_co8"}, {31'b0, co8}, 32'd0);
    chk({tag, "_v8"},  {31'b0, v8}, 32'd0);
    chk({tag, "_y16"}, {16'b0, y16}, 32'd0);
  endtask

  initial begin
    rst = 1'b0; en8 = 1'b0; en16 = 1'b0;
    a8 = '0; b8 = '0; a16 = '0; b16 = '0;
    last8 = '0; last16 = '0;

    // Reset with a load pending: outputs clear at once and stay clear.
    #2;
    en8 = 1'b1; a8 = 8'h55; b8 = 5'h1F;
    rst = 1'b1;
    #1 chk_zero("rst_imm");
    @(posedge clk); #1 chk_zero("rst_held");
    @(posedge clk); #3;
    rst = 1'b0;
    cyc8(1'b1, 8'h55, 5'h1F);                 // 0x74, co 0

    // Basic sums, back to back.
    cyc8(1'b1, 8'b0000_0100, 5'b00100);       // 8
    cyc8(1'b1, 8'b0000_0010, 5'b00011);       // 5
    cyc8(1'b1, 8'h3C, 5'd0);                  // B=0 -> Y=A
    // Hold: idle with X-free but changed inputs, then X inputs.
    cyc8(1'b0, 8'hFF, 5'h1F);
    cyc8(1'b0, 8'hxx, 5'bx_xxxx);
    // Overflow cases.
    cyc8(1'b1, 8'hFF, 5'd1);
    cyc8(1'b1, 8'hF0, 5'd31);
    cyc8(1'b1, 8'hFF, 5'd31);
    cyc8(1'b0, 8'h00, 5'd0);
    // Random back-to-back burst with occasional idles.
    for (int i = 0; i < 40; i++)
      cyc8(($urandom_range(3, 0) != 0), 8'($urandom), 5'($urandom));

    // Mid-stream reset between edges while loading.
    cyc8(1'b1, 8'h10, 5'd7);
    cyc8(1'b1, 8'h20, 5'd9);
    #2 rst = 1'b1;
    #1 chk_zero("rst_mid");
    #1 rst = 1'b0;
    last8 = '0;
    cyc8(1'b1, 8'hA0, 5'd17);                 // fresh sum after reset
    cyc8(1'b0, 8'h00, 5'd0);

    // P=16 instance.
    cyc16(1'b1, 16'hFFE0, 5'd31);             // FFFF, co 0
    cyc16(1'b1, 16'hFFFF, 5'd1);              // wrap/clamp, co 1
    cyc16(1'b1, 16'h1234, 5'd0);
    cyc16(1'b0, 16'h0000, 5'd0);

    chk("q8_drained",  q8.size(),  32'd0);
    chk("q16_drained", q16.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
